// File: rtl/lsu_pkg.sv
// Shared encodings, byte-select constants, FSM states and request metadata for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B    = 4'b0001;
  localparam logic [3:0] SEL_HLO  = 4'b0011;
  localparam logic [3:0] SEL_HHI  = 4'b1100;
  localparam logic [3:0] SEL_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } meta_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte selects and store-lane replication from size/addr, plus load-lane extract and extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata_i[{lane_i, 3'b000} +: 8];
    half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sel_o   = SEL_NONE;
    wdat_o  = wdata_i;
    rdata_o = '0;
    case (size_i)
      SIZE_B: begin
        sel_o   = SEL_B << lane_i;
        wdat_o  = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SIZE_H: begin
        sel_o   = lane_i[1] ? SEL_HHI : SEL_HLO;
        wdat_o  = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      SIZE_W: begin
        sel_o   = SEL_W;
        rdata_o = rdata_i;
      end
      default: begin
        sel_o = SEL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: byte/half/word accesses -> held word-aligned bus requests; optional bus timeout via LSU_TIMEOUT_EN.
// Latency: bus request one cycle after acceptance, response one cycle after ack/err; faults respond next cycle.
// Backpressure: req_ready_o only in IDLE; the request is held until the bridge acks or errors.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_misalign_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_re_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  state_t      state_q, state_d;
  meta_t       meta_q, meta_d;
  logic [31:0] wbm_addr_q, wbm_addr_d;
  logic [31:0] wbm_dat_q, wbm_dat_d;
  logic [3:0]  wbm_sel_q, wbm_sel_d;
  logic        wbm_we_q, wbm_we_d;
  logic        wbm_re_q, wbm_re_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_misalign_q, rsp_misalign_d;

  logic        accept, misalign, illegal, tmo_expire;
  logic [1:0]  al_size, al_lane;
  logic        al_uns;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat, al_rdata;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  // Counter sits at zero outside BUS, so it is clear on every entry.
  always_comb begin
    tmo_d      = (state_q == ST_BUS) ? tmo_q + CNT_W'(1) : '0;
    tmo_expire = (state_q == ST_BUS) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_expire = 1'b0;
`endif

  assign accept   = req_valid_i && (state_q == ST_IDLE);
  assign misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign illegal  = (req_size_i == SIZE_X);

  // One lane unit serves both directions: request fields while idle, stored metadata otherwise.
  always_comb begin
    al_size = (state_q == ST_IDLE) ? req_size_i      : meta_q.size;
    al_lane = (state_q == ST_IDLE) ? req_addr_i[1:0] : meta_q.lane;
    al_uns  = meta_q.uns;
  end

  lsu_align u_align (
    .size_i  (al_size),
    .lane_i  (al_lane),
    .wdata_i (req_wdata_i),
    .uns_i   (al_uns),
    .rdata_i (wbm_dat_i),
    .sel_o   (al_sel),
    .wdat_o  (al_wdat),
    .rdata_o (al_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      meta_q         <= '0;
      wbm_addr_q     <= '0;
      wbm_dat_q      <= '0;
      wbm_sel_q      <= '0;
      wbm_we_q       <= 1'b0;
      wbm_re_q       <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      meta_q         <= meta_d;
      wbm_addr_q     <= wbm_addr_d;
      wbm_dat_q      <= wbm_dat_d;
      wbm_sel_q      <= wbm_sel_d;
      wbm_we_q       <= wbm_we_d;
      wbm_re_q       <= wbm_re_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_misalign_q <= rsp_misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (illegal || misalign) ? ST_RESP : ST_BUS;
      ST_BUS:  if (wbm_err_i || wbm_ack_i || tmo_expire) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    meta_d         = meta_q;
    wbm_addr_d     = wbm_addr_q;
    wbm_dat_d      = wbm_dat_q;
    wbm_sel_d      = wbm_sel_q;
    wbm_we_d       = wbm_we_q;
    wbm_re_d       = wbm_re_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    rsp_misalign_d = rsp_misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal || misalign) begin
            rsp_rdata_d    = '0;
            rsp_err_d      = illegal;
            rsp_misalign_d = !illegal;
          end else begin
            meta_d     = '{size: req_size_i, uns: req_unsigned_i, lane: req_addr_i[1:0]};
            wbm_addr_d = {req_addr_i[31:2], 2'b00};
            wbm_dat_d  = req_we_i ? al_wdat : '0;
            wbm_sel_d  = al_sel;
            wbm_we_d   = req_we_i;
            wbm_re_d   = !req_we_i;
          end
        end
      end
      ST_BUS: begin
        if (wbm_err_i || wbm_ack_i || tmo_expire) begin
          wbm_we_d       = 1'b0;
          wbm_re_d       = 1'b0;
          rsp_misalign_d = 1'b0;
          // Error beats a simultaneous ack; ack beats an expiring timeout.
          rsp_err_d      = wbm_err_i || !wbm_ack_i;
          rsp_rdata_d    = (wbm_err_i || !wbm_ack_i || wbm_we_q) ? '0 : al_rdata;
        end
      end
      default: begin
        wbm_we_d = wbm_we_q;
      end
    endcase
  end

  always_comb begin
    req_ready_o    = (state_q == ST_IDLE);
    stall_o        = (state_q != ST_IDLE);
    rsp_valid_o    = (state_q == ST_RESP);
    rsp_rdata_o    = rsp_rdata_q;
    rsp_err_o      = rsp_err_q;
    rsp_misalign_o = rsp_misalign_q;
    wbm_addr_o     = wbm_addr_q;
    wbm_dat_o      = wbm_dat_q;
    wbm_sel_o      = wbm_sel_q;
    wbm_we_o       = wbm_we_q;
    wbm_re_o       = wbm_re_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses queued at issue, compared when rsp_valid_o pulses.
`timescale 1ns/1ps
module tb_lsu;

  localparam int TMO     = 4;
  localparam int BM_ACK  = 0;
  localparam int BM_ERR  = 1;
  localparam int BM_BOTH = 2;
  localparam int BM_NONE = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, stall_o, rsp_valid_o, rsp_err_o, rsp_misalign_o;
  logic [31:0] rsp_rdata_o, wbm_addr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_re_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .stall_o(stall_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_misalign_o(rsp_misalign_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_re_o(wbm_re_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [31:0] rdata, input logic err, input logic mis);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    r.mis   = mis;
    return r;
  endfunction

  rsp_t got_e;
  always @(negedge clk_i) begin
    if (rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, got_e.rdata);
        check("rsp_err", {31'b0, rsp_err_o}, {31'b0, got_e.err});
        check("rsp_mis", {31'b0, rsp_misalign_o}, {31'b0, got_e.mis});
        check("rsp_stall", {31'b0, stall_o}, 32'd1);
      end
    end
  end

  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit fault,
                        input int mode, input int delay, input logic [31:0] bus_rdata,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat, input rsp_t exp);
    exp_q.push_back(exp);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (fault) begin
      check({tag, "_flt_vld"}, {31'b0, rsp_valid_o}, 32'd1);
      check({tag, "_flt_bus"}, {30'b0, wbm_we_o, wbm_re_o}, 32'd0);
    end else begin
      check({tag, "_addr"}, wbm_addr_o, {addr[31:2], 2'b00});
      check({tag, "_sel"}, {28'b0, wbm_sel_o}, {28'b0, exp_sel});
      if (we) check({tag, "_dat"}, wbm_dat_o, exp_dat);
      check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd0);
      for (int i = 0; i < delay; i++) begin
        check({tag, "_hold"}, {30'b0, wbm_we_o, wbm_re_o}, {30'b0, we, !we});
        check({tag, "_hold_sel"}, {28'b0, wbm_sel_o}, {28'b0, exp_sel});
        @(negedge clk_i);
      end
      if (mode != BM_NONE) begin
        check({tag, "_pre_ack"}, {30'b0, wbm_we_o, wbm_re_o}, {30'b0, we, !we});
        wbm_dat_i = bus_rdata;
        wbm_ack_i = (mode != BM_ERR);
        wbm_err_i = (mode != BM_ACK);
        @(negedge clk_i);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
      end
      check({tag, "_rsp_lat"}, {31'b0, rsp_valid_o}, 32'd1);
      check({tag, "_bus_drop"}, {30'b0, wbm_we_o, wbm_re_o}, 32'd0);
    end
    @(negedge clk_i);
    check({tag, "_pulse"}, {31'b0, rsp_valid_o}, 32'd0);
    check({tag, "_idle"}, {30'b0, req_ready_o, stall_o}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    #1;
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_ctl", {27'b0, stall_o, rsp_valid_o, rsp_err_o, rsp_misalign_o, wbm_we_o | wbm_re_o}, 32'd0);
    check("rst_addr", wbm_addr_o, 32'd0);
    check("rst_sel_dat", {wbm_dat_o[27:0], wbm_sel_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    access("wld",   0, 2'b10, 0, 32'h0000_1004, 0, 0, BM_ACK, 3, 32'hDEAD_BEEF, 4'b1111, 0, mk(32'hDEAD_BEEF, 0, 0));
    access("bld_s", 0, 2'b00, 0, 32'h0000_1003, 0, 0, BM_ACK, 1, 32'h80FF_0000, 4'b1000, 0, mk(32'hFFFF_FF80, 0, 0));
    access("bld_u", 0, 2'b00, 1, 32'h0000_1003, 0, 0, BM_ACK, 0, 32'h80FF_0000, 4'b1000, 0, mk(32'h0000_0080, 0, 0));
    access("hst",   1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 0, BM_ACK, 2, 0, 4'b1100, 32'hABCD_ABCD, mk(0, 0, 0));
    access("bst",   1, 2'b00, 0, 32'h0000_3001, 32'hAABB_CC5A, 0, BM_ACK, 0, 0, 4'b0010, 32'h5A5A_5A5A, mk(0, 0, 0));
    access("hld_s", 0, 2'b01, 0, 32'h0000_3000, 0, 0, BM_ACK, 1, 32'h1234_8001, 4'b0011, 0, mk(32'hFFFF_8001, 0, 0));
    access("hld_u", 0, 2'b01, 1, 32'h0000_3002, 0, 0, BM_ACK, 1, 32'h9ABC_1111, 4'b1100, 0, mk(32'h0000_9ABC, 0, 0));
    access("bld_p", 0, 2'b00, 0, 32'h0000_3001, 0, 0, BM_ACK, 0, 32'h0000_7F00, 4'b0010, 0, mk(32'h0000_007F, 0, 0));
    access("wst",   1, 2'b10, 0, 32'h0000_4000, 32'hCAFE_F00D, 0, BM_ACK, 0, 0, 4'b1111, 32'hCAFE_F00D, mk(0, 0, 0));
    access("both",  0, 2'b10, 0, 32'h0000_5000, 0, 0, BM_BOTH, 1, 32'h1111_1111, 4'b1111, 0, mk(0, 1, 0));
    access("berr",  1, 2'b00, 0, 32'h0000_3003, 32'h0000_0077, 0, BM_ERR, 1, 0, 4'b1000, 32'h7777_7777, mk(0, 1, 0));

    access("mis_w", 0, 2'b10, 0, 32'h0000_2001, 0, 1, BM_ACK, 0, 0, 0, 0, mk(0, 0, 1));
    access("mis_h", 1, 2'b01, 0, 32'h0000_2003, 32'h5555_5555, 1, BM_ACK, 0, 0, 0, 0, mk(0, 0, 1));
    access("ill",   0, 2'b11, 0, 32'h0000_2000, 0, 1, BM_ACK, 0, 0, 0, 0, mk(0, 1, 0));
    access("ill_m", 0, 2'b11, 0, 32'h0000_2001, 0, 1, BM_ACK, 0, 0, 0, 0, mk(0, 1, 0));

`ifdef LSU_TIMEOUT_EN
    access("tmo",     0, 2'b10, 0, 32'h0000_6000, 0, 0, BM_NONE, TMO, 0, 4'b1111, 0, mk(0, 1, 0));
    access("tmo_ack", 0, 2'b10, 0, 32'h0000_6004, 0, 0, BM_ACK, TMO - 1, 32'h0BAD_F00D, 4'b1111, 0, mk(32'h0BAD_F00D, 0, 0));
`endif

    // Reset while a load is outstanding: request drops at once and no response follows.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0000_7000;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("rbus_re", {31'b0, wbm_re_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rbus_drop", {30'b0, wbm_we_o, wbm_re_o}, 32'd0);
    check("rbus_state", {29'b0, req_ready_o, stall_o, rsp_valid_o}, 32'd4);
    @(negedge clk_i);
    rst_i = 1'b0;
    wbm_ack_i = 1'b1;
    @(negedge clk_i);
    wbm_ack_i = 1'b0;
    check("rbus_norsp", {31'b0, rsp_valid_o}, 32'd0);
    @(negedge clk_i);

    access("post_rst", 0, 2'b00, 1, 32'h0000_8002, 0, 0, BM_ACK, 0, 32'h00C3_0000, 4'b0100, 0, mk(32'h0000_00C3, 0, 0));

    @(negedge clk_i);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the pipeline memory stage and the Wishbone bridge (`WBU`). It accepts one byte, halfword or word access at a time. It converts each access into a word-aligned request with byte selects and holds that request stable until the bridge acknowledges it. Load data is extracted from the correct lanes and sign- or zero-extended, and misaligned or illegal accesses are reported without issuing a bus cycle.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-wait limit in cycles; used only when the timeout feature is compiled in (see Configuration).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_valid_i` in 1: pipeline presents an access.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned_i` in 1: 1 = zero-extend load data, 0 = sign-extend.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `req_ready_o` out 1: unit is idle and can accept an access.
- `stall_o` out 1: high from acceptance until the response cycle (response cycle included).
- `rsp_valid_o` out 1: single-cycle response pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and faults.
- `rsp_err_o` out 1: bus error, timeout, or illegal size.
- `rsp_misalign_o` out 1: misaligned access, no bus cycle issued.
- `wbm_addr_o` out 32: word address, bits [1:0] forced to 0.
- `wbm_dat_o` out 32: lane-replicated store data.
- `wbm_sel_o` out 4: byte selects.
- `wbm_we_o` out 1: write request level.
- `wbm_re_o` out 1: read request level.
- `wbm_dat_i` in 32: read data from the bridge.
- `wbm_ack_i` in 1: bridge completion.
- `wbm_err_i` in 1: bridge error.

## Operation
- FSM states: IDLE, BUS, RESP.
- Reset state: IDLE, with every output 0 except `req_ready_o` = 1.
- Acceptance: an access is accepted when `req_valid_i` and `req_ready_o` are both high; `req_ready_o` = (state == IDLE).
- Misalign check at acceptance: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Go to RESP with `rsp_misalign_o` = 1 and no bus activity.
- Size 11 at acceptance: go to RESP with `rsp_err_o` = 1 and no bus activity. If the access is also misaligned, the illegal-size error wins.
- Otherwise go to BUS and register the request:
  - `wbm_addr_o` = {addr[31:2], 2'b00}.
  - `wbm_we_o` = req_we_i; `wbm_re_o` = !req_we_i.
- Byte selects:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unchanged.
- BUS state:
  - All `wbm_*` outputs are held constant.
  - On `wbm_err_i`: go to RESP with `rsp_err_o` = 1.
  - Else on `wbm_ack_i`: capture `wbm_dat_i`, go to RESP.
  - On leaving BUS, `wbm_re_o` and `wbm_we_o` drop to 0.
- Load extraction: take the lane selected by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend to 32 bits per `req_unsigned_i`.
- RESP state: `rsp_valid_o` = 1 for exactly one cycle, then return to IDLE. Response fields hold their values until the next response.

## Timing
- Accepted at edge N: `wbm_re_o`/`wbm_we_o` high after edge N.
- `wbm_ack_i` sampled at edge N+k: `rsp_valid_o` high during cycle N+k+1.
- Back-to-back issue: the earliest next acceptance is the cycle after `rsp_valid_o`.
- Fault path (misalign or illegal size): `rsp_valid_o` high in the cycle after acceptance.
- Ack and err in the same cycle: err wins and `rsp_rdata_o` = 0.
- Reset mid-access: `wbm_re_o`/`wbm_we_o` drop immediately (asynchronously), no response is produced, and the FSM returns to IDLE.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to BUS and increments each BUS cycle.
  - If it reaches `TIMEOUT_CYCLES` with no ack/err, drop the request and go to RESP with `rsp_err_o` = 1.
  - An ack in the expiry cycle wins over the timeout.
- `LSU_TIMEOUT_EN` undefined: BUS waits indefinitely, and the counter logic and `TIMEOUT_CYCLES` have no effect.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - FSM state enum;
  - `SEL_*` constants.
- Sub-module `lsu_align`: purely combinational; produces sel and store lanes from size/addr, and extracts/extends load lanes. The FSM stays in the `lsu` top.

## Test plan
- Word load at 0x0000_1004, bridge acks after 3 cycles with 0xDEADBEEF:
  - `wbm_addr_o` = 0x1004, sel = 1111;
  - `rsp_rdata_o` = 0xDEADBEEF exactly one cycle after the ack.
- Byte load at 0x1003 of 0x80FF_0000, signed:
  - sel = 1000, rdata = 0xFFFF_FF80;
  - repeated with unsigned: rdata = 0x0000_0080.
- Half store of 0x1234_ABCD at 0x2002:
  - sel = 1100, `wbm_dat_o` = 0xABCD_ABCD, `wbm_we_o` held until ack.
- Word load at 0x2001, and a half access at 0x2003:
  - `rsp_misalign_o` = 1, `wbm_re_o`/`wbm_we_o` never rise.
  - Size 11 at 0x2000: `rsp_err_o` = 1, no bus cycle.
- Ack and err asserted together: `rsp_err_o` = 1, rdata = 0.
- Reset asserted in BUS: outputs clear within the reset cycle.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, no ack: `rsp_err_o` = 1 after 4 BUS cycles, `wbm_re_o` dropped.
